// File: rtl/jk_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jk_seq_ctrl
// Purpose  : Sequencer for a WIDTH-bit register built from JK flip-flops.
//            It loads a start value and then steps the register through a
//            selected count sequence (up, down, Gray up, rotate-left) for a
//            programmed number of cycles. Completion is signalled with a
//            one-cycle done pulse.
// Ports    : clk       - rising-edge clock
//            reset     - asynchronous, active-low reset
//            pause     - (JK_SEQ_CTRL_PAUSE_EN only) freeze the run
//            start     - run request, sampled only in IDLE
//            mode      - 00 up, 01 down, 10 Gray up, 11 rotate-left
//            load_val  - initial register value, captured with start
//            len       - number of steps after the load
//            q         - JK register state
//            busy      - high while running
//            done      - one-cycle completion pulse
//            wrap      - one-cycle pulse after a sequence wrap
// Config   : define JK_SEQ_CTRL_PAUSE_EN to add the pause input.
// Revision : 1.0 - initial release
// ============================================================================
module jk_seq_ctrl #(
  parameter int WIDTH = 3,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef JK_SEQ_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gray code of the all-ones binary value: MSB set, all others clear.
  localparam logic [WIDTH-1:0] GRAY_MAX = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [1:0]       mode_lat;
  logic [LEN_W-1:0] remaining;

  logic             advance;
  logic             step_wrap;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_next;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

`ifdef JK_SEQ_CTRL_PAUSE_EN
  assign advance = (state == RUN) && !pause;
`else
  assign advance = (state == RUN);
`endif

  // Next value of the sequence and whether taking it counts as a wrap.
  always_comb begin
    step_val  = q;
    step_wrap = 1'b0;
    case (mode_lat)
      2'b00: begin
        step_val  = q + WIDTH'(1);
        step_wrap = &q;
      end
      2'b01: begin
        step_val  = q - WIDTH'(1);
        step_wrap = ~|q;
      end
      2'b10: begin
        step_val  = bin2gray(gray2bin(q) + WIDTH'(1));
        step_wrap = (q == GRAY_MAX);
      end
      default: begin
        step_val  = {q[WIDTH-2:0], q[WIDTH-1]};
        step_wrap = 1'b0;
      end
    endcase
  end

  // Target value for the next edge, converted to JK excitation. Any bit
  // whose target equals its current value gets J=K=0 (hold).
  always_comb begin
    target = q;
    if (state == IDLE && start) begin
      target = load_val;
    end else if (advance) begin
      target = step_val;
    end
    j      = ~q & target;
    k      = q & ~target;
    // JK characteristic equation: Q+ = J & ~Q | ~K & Q
    q_next = (j & ~q) | (~k & q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      q         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      remaining <= '0;
      mode_lat  <= 2'b00;
    end else begin
      q    <= q_next;
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_lat  <= mode;
            remaining <= len;
            if (len != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (advance) begin
            wrap      <= step_wrap;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_seq_ctrl
// Purpose  : Directed self-checking bench for jk_seq_ctrl (WIDTH=3, LEN_W=8).
//            Inputs change 1 time unit after each rising edge and outputs are
//            sampled there too. With JK_SEQ_CTRL_PAUSE_EN defined the pause
//            port is connected and exercised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [2:0] load_val;
  logic [7:0] len;
  logic [2:0] q;
  logic       busy;
  logic       done;
  logic       wrap;
`ifdef JK_SEQ_CTRL_PAUSE_EN
  logic       pause;
`endif

  int checks = 0;
  int errors = 0;
  logic [2:0] prev_q;

  jk_seq_ctrl #(.WIDTH(3), .LEN_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef JK_SEQ_CTRL_PAUSE_EN
    .pause    (pause),
`endif
    .start    (start),
    .mode     (mode),
    .load_val (load_val),
    .len      (len),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check all four outputs at once.
  task automatic check_all(input string tag, input logic [2:0] eq,
                           input logic eb, input logic ed, input logic ew);
    check({tag, ".q"},    32'(q),    32'(eq));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
    check({tag, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    mode     = 2'b00;
    load_val = 3'd0;
    len      = 8'd0;
`ifdef JK_SEQ_CTRL_PAUSE_EN
    pause    = 1'b0;
`endif
    #1;
    check_all("reset_async", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_all("reset_held", 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check_all("idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Up wrap: 6,7,0,1
    start = 1'b1; mode = 2'b00; load_val = 3'd6; len = 8'd3;
    tick();
    check_all("up.load", 3'd6, 1'b1, 1'b0, 1'b0);
    start = 1'b0; mode = 2'b01; load_val = 3'd2; len = 8'd9;  // ignored now
    tick();
    check_all("up.s1", 3'd7, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("up.s2", 3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    check_all("up.done", 3'd1, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("up.idle", 3'd1, 1'b0, 1'b0, 1'b0);

    // Down wrap: 1,0,7
    start = 1'b1; mode = 2'b01; load_val = 3'd1; len = 8'd2;
    tick();
    check_all("dn.load", 3'd1, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    check_all("dn.s1", 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("dn.done", 3'd7, 1'b0, 1'b1, 1'b1);
    tick();
    check_all("dn.idle", 3'd7, 1'b0, 1'b0, 1'b0);

    // Gray up: 000,001,011,010,110
    start = 1'b1; mode = 2'b10; load_val = 3'b000; len = 8'd4;
    tick();
    check_all("gr.load", 3'b000, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    prev_q = q;
    tick();
    check_all("gr.s1", 3'b001, 1'b1, 1'b0, 1'b0);
    check("gr.s1.onebit", 32'($countones(q ^ prev_q)), 32'd1);
    prev_q = q;
    tick();
    check_all("gr.s2", 3'b011, 1'b1, 1'b0, 1'b0);
    check("gr.s2.onebit", 32'($countones(q ^ prev_q)), 32'd1);
    prev_q = q;
    tick();
    check_all("gr.s3", 3'b010, 1'b1, 1'b0, 1'b0);
    check("gr.s3.onebit", 32'($countones(q ^ prev_q)), 32'd1);
    prev_q = q;
    tick();
    check_all("gr.done", 3'b110, 1'b0, 1'b1, 1'b0);
    check("gr.s4.onebit", 32'($countones(q ^ prev_q)), 32'd1);
    tick();

    // Gray wrap from gray(7)=100; load edge at a wrap point must not wrap.
    start = 1'b1; mode = 2'b10; load_val = 3'b100; len = 8'd1;
    tick();
    check_all("grw.load", 3'b100, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    check_all("grw.done", 3'b000, 1'b0, 1'b1, 1'b1);
    tick();

    // Up load at all-ones: no wrap on the load edge.
    start = 1'b1; mode = 2'b00; load_val = 3'd7; len = 8'd1;
    tick();
    check_all("upw.load", 3'd7, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    check_all("upw.done", 3'd0, 1'b0, 1'b1, 1'b1);
    tick();

    // Rotate-left: 001 -> 010 -> 100 -> 001, never wraps.
    start = 1'b1; mode = 2'b11; load_val = 3'b001; len = 8'd3;
    tick();
    check_all("rot.load", 3'b001, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    check_all("rot.s1", 3'b010, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("rot.s2", 3'b100, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("rot.done", 3'b001, 1'b0, 1'b1, 1'b0);
    tick();

    // len=0: straight to DONE, busy stays low.
    start = 1'b1; mode = 2'b00; load_val = 3'd5; len = 8'd0;
    tick();
    check_all("len0.done", 3'd5, 1'b0, 1'b1, 1'b0);
    // start held through DONE: ignored there.
    load_val = 3'd2; len = 8'd1;
    tick();
    check_all("len0.idle", 3'd5, 1'b0, 1'b0, 1'b0);
    // still high in IDLE: accepted.
    tick();
    check_all("reacc.load", 3'd2, 1'b1, 1'b0, 1'b0);
    // start high in RUN with new values: ignored.
    load_val = 3'd7; len = 8'd5; mode = 2'b01;
    tick();
    check_all("reacc.done", 3'd3, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    check_all("reacc.idle", 3'd3, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("reacc.hold", 3'd3, 1'b0, 1'b0, 1'b0);

    // Mid-run reset.
    start = 1'b1; mode = 2'b00; load_val = 3'd2; len = 8'd5;
    tick();
    check_all("mrst.load", 3'd2, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    check_all("mrst.s1", 3'd3, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_all("mrst.async", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all("mrst.after", 3'd0, 1'b0, 1'b0, 1'b0);
    end

`ifdef JK_SEQ_CTRL_PAUSE_EN
    // Pause two cycles mid-run: 0,1,(1),(1),2,3,4.
    start = 1'b1; mode = 2'b00; load_val = 3'd0; len = 8'd4;
    tick();
    check_all("pa.load", 3'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    check_all("pa.s1", 3'd1, 1'b1, 1'b0, 1'b0);
    pause = 1'b1;
    tick();
    check_all("pa.p1", 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("pa.p2", 3'd1, 1'b1, 1'b0, 1'b0);
    pause = 1'b0;
    tick();
    check_all("pa.s2", 3'd2, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("pa.s3", 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("pa.done", 3'd4, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("pa.idle", 3'd4, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
